tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 16: consecutive control tokens required to declare lock.
REQ-002 Parameter SEARCH_WINDOW, default 1024: cycles spent at one bit offset before slipping.
REQ-003 Parameter LOSS_TIMEOUT, default 2048: cycles without any control token before lock is dropped.
REQ-004 clk_i  in  1  pixel clock; one clock only; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 raw_i  in  10  deserialized channel bits, arbitrary word alignment; raw_i[0] is the earliest bit.
REQ-007 data_o  out  8  decoded pixel byte.
REQ-008 ctrl_o  out  2  decoded control bits {c1,c0}.
REQ-009 de_o  out  1  1 = data_o valid, 0 = control period.
REQ-010 valid_o  out  1  data_o, ctrl_o and de_o qualified; equals locked state.
REQ-011 locked_o  out  1  aligner in LOCKED.
REQ-012 offset_o  out  4  current bit offset, 0..9.
REQ-013 lock_loss_o  out  8  lock-loss count (see Configuration).

Function
REQ-014 Each cycle: window[19:0] <= {raw_i, window[19:10]}; sym = window[offset+9:offset].
REQ-015 Control tokens: sym 10'h354 -> ctrl 00; 10'h0AB -> 01; 10'h154 -> 10; 10'h2AB -> 11.
REQ-016 Data decode: q = sym[9] ? ~sym[7:0] : sym[7:0]; d[0] = q[0]; for i = 1..7, d[i] = q[i]^q[i-1] if sym[8] = 1, else ~(q[i]^q[i-1]).
REQ-017 Outputs are registered one cycle after the window update; raw_i to outputs latency is 2 cycles for offset 0.
REQ-018 When sym is a control token: de_o = 0, ctrl_o = token value, data_o = 0.
REQ-019 When sym is not a control token: de_o = 1, data_o = decoded byte, ctrl_o holds its last value.
REQ-020 While not LOCKED, valid_o, de_o, data_o and ctrl_o are all 0.
REQ-021 FSM has two states, SEARCH and LOCKED.
REQ-022 SEARCH: run counter increments on each control token and clears on any non-control sym.
REQ-023 SEARCH: when run reaches LOCK_COUNT, the FSM enters LOCKED on the next edge.
REQ-024 SEARCH: window counter increments every cycle; at SEARCH_WINDOW-1 without lock, offset advances (9 wraps to 0) and the window and run counters clear.
REQ-025 If lock is reached and the window expires in the same cycle, lock wins and offset is unchanged.
REQ-026 LOCKED: timeout counter clears on each control token and otherwise increments.
REQ-027 LOCKED: at LOSS_TIMEOUT-1, the FSM returns to SEARCH, keeps offset, and clears the run and window counters.
REQ-028 Data symbols never cause a lock loss on their own; only the timeout does.
REQ-029 Counters are sized to their parameter and never wrap.

Reset
REQ-030 Reset has priority over all other behaviour, including mid-search and mid-lock.
REQ-031 While reset is asserted: state = SEARCH; offset = 0; window and all counters = 0; every output = 0 (lock_loss_o included).
REQ-032 The first outputs are qualified no earlier than LOCK_COUNT+2 cycles after reset deasserts.

Configuration
REQ-033 Macro TMDS_DECODER_LOCK_LOSS_EN defined: lock_loss_o increments on each LOCKED->SEARCH transition and saturates at 255.
REQ-034 Macro TMDS_DECODER_LOCK_LOSS_EN undefined: lock_loss_o is constant 0, no counter logic is present, and the port list is unchanged.

Verification
REQ-035 Lock: reset, then 16x 10'h354 at offset 0 -> locked_o = 1 within 18 cycles, offset_o = 0, ctrl_o = 00, de_o = 0.
REQ-036 Decode: locked, then feed the encoded byte 8'hA5 (both sym[9] polarities, both sym[8] modes) -> data_o = 8'hA5, de_o = 1, 2 cycles after input.
REQ-037 Slip: the stream is bit-rotated by 3, with a control run every 800 cycles -> offset_o steps 0,1,2,3, then lock at offset 3 after about 3x1024 cycles; no lock at offsets 0-2.
REQ-038 Wrap: the stream is rotated by 9, then lock is forced to search again -> offset goes 9 to 0 after a window expiry.
REQ-039 Loss: locked, then 2048 data-only symbols -> locked_o falls, valid_o = 0, lock_loss_o = 1 (with macro) or 0 (without).
REQ-040 Reset mid-lock: reset asserted while LOCKED -> next cycle all outputs 0, offset_o = 0, and relock follows REQ-035.

Source files
------------

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with word aligner: finds symbol alignment, then decodes data and control symbols.
// Latency: raw_i captured on edge N appears on the outputs after edge N+2 (offset 0).
// Backpressure: none; one symbol per clk_i, outputs are unqualified (valid_o = 0) while searching.
//
// Ports:
//   clk_i        pixel clock
//   reset        synchronous active-high reset
//   raw_i[9:0]   deserialized channel bits, raw_i[0] earliest, arbitrary word alignment
//   data_o[7:0]  decoded pixel byte (de_o = 1)
//   ctrl_o[1:0]  decoded control bits {c1,c0}, held through data periods
//   de_o         1 = data period, 0 = control period
//   valid_o      data_o/ctrl_o/de_o qualified (aligner locked)
//   locked_o     aligner in LOCKED
//   offset_o     current bit offset into the 20-bit window, 0..9
//   lock_loss_o  LOCKED->SEARCH count, saturating at 255; only counts when
//                TMDS_DECODER_LOCK_LOSS_EN is defined, otherwise tied to 0
module tmds_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOSS_TIMEOUT  = 2048
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic [9:0] raw_i,
  output logic [7:0] data_o,
  output logic [1:0] ctrl_o,
  output logic       de_o,
  output logic       valid_o,
  output logic       locked_o,
  output logic [3:0] offset_o,
  output logic [7:0] lock_loss_o
);

  localparam int RUN_W = (LOCK_COUNT + 1 > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int WIN_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int TMO_W = (LOSS_TIMEOUT > 1) ? $clog2(LOSS_TIMEOUT) : 1;

  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOSS_TIMEOUT - 1);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [19:0]      window;
  logic [RUN_W-1:0] run_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [TMO_W-1:0] tmo_cnt;

  logic [9:0] sym;
  logic       is_ctrl;
  logic [1:0] ctrl_val;
  logic [7:0] q;
  logic [7:0] dec;
  logic       lock_now;
  logic       win_exp;
  logic       loss_now;
  logic       locked_next;

  // Older word sits in window[9:0]; a non-zero offset borrows the low bits of the newer word.
  assign sym = window[offset_o +: 10];

  always_comb begin
    is_ctrl  = 1'b1;
    ctrl_val = 2'b00;
    case (sym)
      10'h354: ctrl_val = 2'b00;
      10'h0AB: ctrl_val = 2'b01;
      10'h154: ctrl_val = 2'b10;
      10'h2AB: ctrl_val = 2'b11;
      default: is_ctrl  = 1'b0;
    endcase
  end

  // TMDS stage-2 undo (sym[9]) then transition-minimised undo (sym[8] selects XOR/XNOR).
  always_comb begin
    q      = sym[9] ? ~sym[7:0] : sym[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Lock takes priority over a window expiry landing on the same edge.
  assign lock_now    = (state == SEARCH) && (run_cnt == RUN_LOCK);
  assign win_exp     = (state == SEARCH) && (win_cnt == WIN_LAST);
  assign loss_now    = (state == LOCKED) && !is_ctrl && (tmo_cnt == TMO_LAST);
  assign locked_next = lock_now || ((state == LOCKED) && !loss_now);

  assign locked_o = (state == LOCKED);

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state    <= SEARCH;
      window   <= '0;
      offset_o <= '0;
      run_cnt  <= '0;
      win_cnt  <= '0;
      tmo_cnt  <= '0;
      data_o   <= '0;
      ctrl_o   <= '0;
      de_o     <= 1'b0;
      valid_o  <= 1'b0;
    end else begin
      window <= {raw_i, window[19:10]};

      case (state)
        SEARCH: begin
          if (lock_now) begin
            state   <= LOCKED;
            tmo_cnt <= '0;
          end else if (win_exp) begin
            offset_o <= (offset_o == 4'd9) ? 4'd0 : offset_o + 4'd1;
            win_cnt  <= '0;
            run_cnt  <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            // run_cnt never passes RUN_LOCK: reaching it forces lock_now next edge.
            run_cnt <= is_ctrl ? run_cnt + 1'b1 : '0;
          end
        end
        LOCKED: begin
          if (loss_now) begin
            state   <= SEARCH;
            run_cnt <= '0;
            win_cnt <= '0;
          end else begin
            tmo_cnt <= is_ctrl ? '0 : tmo_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase

      // Qualify with the state being entered so valid_o tracks locked_o edge for edge.
      if (locked_next) begin
        valid_o <= 1'b1;
        if (is_ctrl) begin
          de_o   <= 1'b0;
          ctrl_o <= ctrl_val;
          data_o <= '0;
        end else begin
          de_o   <= 1'b1;
          data_o <= dec;
        end
      end else begin
        valid_o <= 1'b0;
        de_o    <= 1'b0;
        ctrl_o  <= '0;
        data_o  <= '0;
      end
    end
  end

`ifdef TMDS_DECODER_LOCK_LOSS_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk_i) begin
    if (reset) begin
      loss_cnt <= '0;
    end else if (loss_now && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end

  assign lock_loss_o = loss_cnt;
`else
  assign lock_loss_o = 8'h00;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, slip, wrap, loss and reset-mid-lock.
// Decode results go through a scoreboard queue keyed by the cycle they are due.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
module tb_tmds_decoder;

  localparam int LOCK_COUNT    = 16;
  localparam int SEARCH_WINDOW = 1024;
  localparam int LOSS_TIMEOUT  = 2048;
  // Word driven at falling edge c is captured at rising edge c+1 and is on the outputs after edge c+3.
  localparam int LAT = 3;
`ifdef TMDS_DECODER_LOCK_LOSS_EN
  localparam int LOSS_ONE = 1;
`else
  localparam int LOSS_ONE = 0;
`endif

  logic       clk_i = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] raw_i = '0;
  logic [7:0] data_o;
  logic [1:0] ctrl_o;
  logic       de_o;
  logic       valid_o;
  logic       locked_o;
  logic [3:0] offset_o;
  logic [7:0] lock_loss_o;

  tmds_decoder #(
    .LOCK_COUNT   (LOCK_COUNT),
    .SEARCH_WINDOW(SEARCH_WINDOW),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) dut (
    .clk_i      (clk_i),
    .reset      (reset),
    .raw_i      (raw_i),
    .data_o     (data_o),
    .ctrl_o     (ctrl_o),
    .de_o       (de_o),
    .valid_o    (valid_o),
    .locked_o   (locked_o),
    .offset_o   (offset_o),
    .lock_loss_o(lock_loss_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int         due;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] t_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_ctrl(input logic [9:0] s);
    return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
  endfunction

  // TMDS encoder (inverse of the decode rule) for building data symbols.
  function automatic logic [9:0] enc(input logic [7:0] d, input logic m, input logic inv);
    logic [7:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = m ? (q[i-1] ^ d[i]) : (q[i-1] ^ ~d[i]);
    return {inv, m, (inv ? ~q : q)};
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    s = 10'($urandom_range(0, 1023));
    while (is_ctrl(s)) s = 10'($urandom_range(0, 1023));
    return s;
  endfunction

  task automatic step(input logic [9:0] w);
    raw_i = w;
    @(negedge clk_i);
  endtask

  // Sends symbol t on a serial stream whose word boundary is rotated by r bits.
  task automatic send(input logic [9:0] t, input int r);
    logic [19:0] tmp;
    tmp    = {t, t_prev} >> (10 - r);
    t_prev = t;
    step(tmp[9:0]);
  endtask

  task automatic push_exp(input logic de, input logic [7:0] data, input logic [1:0] ctrl);
    exp_t e;
    e.due  = cyc + LAT;
    e.de   = de;
    e.data = data;
    e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data"},   32'(data_o),      0);
    chk({tag, "_ctrl"},   32'(ctrl_o),      0);
    chk({tag, "_de"},     32'(de_o),        0);
    chk({tag, "_valid"},  32'(valid_o),     0);
    chk({tag, "_locked"}, 32'(locked_o),    0);
    chk({tag, "_offset"}, 32'(offset_o),    0);
    chk({tag, "_loss"},   32'(lock_loss_o), 0);
  endtask

  task automatic do_reset(input string tag);
    reset  = 1'b1;
    t_prev = '0;
    step(10'h000);
    step(10'h000);
    chk_zero(tag);
    reset = 1'b0;
  endtask

  // Feeds 10'h354 at offset 0 until lock; checks lock timing and the first locked outputs.
  task automatic lock_offset0(input string tag);
    int c0;
    int seen;
    c0   = cyc;
    seen = -1;
    for (int i = 0; i < LOCK_COUNT + 6 && seen < 0; i++) begin
      send(10'h354, 0);
      if (locked_o) seen = cyc - c0;
    end
    chk({tag, "_not_early"}, 32'(seen >= LOCK_COUNT + 2), 1);
    chk({tag, "_in_time"},   32'(seen > 0 && seen <= LOCK_COUNT + 3), 1);
    chk({tag, "_valid"},     32'(valid_o),  1);
    chk({tag, "_offset"},    32'(offset_o), 0);
    chk({tag, "_ctrl"},      32'(ctrl_o),   0);
    chk({tag, "_de"},        32'(de_o),     0);
  endtask

  // Scoreboard consumer.
  always @(negedge clk_i) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_due",   32'(cyc),     32'(e.due));
      chk("sb_valid", 32'(valid_o), 1);
      chk("sb_de",    32'(de_o),    32'(e.de));
      chk("sb_data",  32'(data_o),  32'(e.data));
      chk("sb_ctrl",  32'(ctrl_o),  32'(e.ctrl));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         c1;
    int         prev_off;
    int         lock_cyc;
    int         steps;
    int         drop_cyc;
    logic       done;
    logic [7:0] d;
    logic       m;
    logic       inv;
    logic [9:0] s;

    @(negedge clk_i);

    // Reset state, then lock at offset 0.
    do_reset("rst");
    lock_offset0("lock");

    // Decode: A5 in all four sym[9]/sym[8] encodings, control tokens, ctrl hold.
    push_exp(1'b1, 8'hA5, 2'b00); send(enc(8'hA5, 1'b1, 1'b0), 0);
    push_exp(1'b1, 8'hA5, 2'b00); send(enc(8'hA5, 1'b1, 1'b1), 0);
    push_exp(1'b1, 8'hA5, 2'b00); send(enc(8'hA5, 1'b0, 1'b0), 0);
    push_exp(1'b1, 8'hA5, 2'b00); send(enc(8'hA5, 1'b0, 1'b1), 0);
    push_exp(1'b0, 8'h00, 2'b01); send(10'h0AB, 0);
    push_exp(1'b1, 8'hA5, 2'b01); send(enc(8'hA5, 1'b1, 1'b0), 0);
    push_exp(1'b0, 8'h00, 2'b10); send(10'h154, 0);
    push_exp(1'b0, 8'h00, 2'b11); send(10'h2AB, 0);
    for (int i = 0; i < 8; i++) begin
      d   = 8'($urandom_range(0, 255));
      m   = 1'($urandom_range(0, 1));
      inv = 1'($urandom_range(0, 1));
      s   = enc(d, m, inv);
      while (is_ctrl(s)) begin
        d = d + 8'd1;
        s = enc(d, m, inv);
      end
      push_exp(1'b1, d, 2'b11); send(s, 0);
    end
    push_exp(1'b0, 8'h00, 2'b00); send(10'h354, 0);
    for (int i = 0; i < 4; i++) send(10'h354, 0);
    chk("dec_drained", 32'(sb.size()), 0);

    // Loss: data only; the 2048th data symbol drops lock.
    c1 = cyc;
    for (int k = 1; k <= LOSS_TIMEOUT + 1; k++) send(rand_data(), 0);
    chk("loss_hold", 32'(locked_o), 1);
    chk("loss_hold_cyc", 32'(cyc - c1), 32'(LOSS_TIMEOUT + 1));
    send(rand_data(), 0);
    chk("loss_drop",   32'(locked_o),    0);
    chk("loss_valid",  32'(valid_o),     0);
    chk("loss_de",     32'(de_o),        0);
    chk("loss_data",   32'(data_o),      0);
    chk("loss_offset", 32'(offset_o),    0);
    chk("loss_count",  32'(lock_loss_o), 32'(LOSS_ONE));

    // A run of LOCK_COUNT-1 tokens broken by one data symbol must not lock.
    for (int i = 0; i < LOCK_COUNT - 1; i++) send(10'h354, 0);
    send(rand_data(), 0);
    for (int i = 0; i < LOCK_COUNT - 1; i++) send(10'h354, 0);
    for (int i = 0; i < 4; i++) send(rand_data(), 0);
    chk("run_break", 32'(locked_o), 0);
    lock_offset0("relock");

    // Reset mid-lock clears everything on the next edge, then relock.
    reset = 1'b1;
    step(10'h354);
    chk_zero("rst_mid");
    reset  = 1'b0;
    t_prev = '0;
    lock_offset0("relock2");

    // Slip: stream rotated by 3, 20-token control run every 800 symbols.
    do_reset("rst_slip");
    prev_off = 0;
    steps    = 0;
    lock_cyc = -1;
    c1       = cyc;
    done     = 1'b0;
    for (int i = 0; i < 5200 && !done; i++) begin
      send(((i % 800) < 20) ? 10'h354 : rand_data(), 3);
      if (32'(offset_o) != prev_off) begin
        chk("slip_step", 32'(offset_o), 32'((prev_off + 1) % 10));
        prev_off = int'(offset_o);
        steps++;
      end
      if (locked_o) begin
        lock_cyc = cyc - c1;
        done     = 1'b1;
      end
    end
    chk("slip_lock",   32'(locked_o), 1);
    chk("slip_offset", 32'(offset_o), 3);
    chk("slip_steps",  32'(steps),    3);
    chk("slip_time",   32'(lock_cyc >= 3 * SEARCH_WINDOW && lock_cyc < 4 * SEARCH_WINDOW), 1);

    // Wrap: stream rotated by 9, lock at 9, force loss, then 9 -> 0 after one window.
    do_reset("rst_wrap");
    done = 1'b0;
    for (int i = 0; i < 11 * SEARCH_WINDOW && !done; i++) begin
      send(((i % 800) < 20) ? 10'h354 : rand_data(), 9);
      if (locked_o) done = 1'b1;
    end
    chk("wrap_lock",   32'(locked_o), 1);
    chk("wrap_offset", 32'(offset_o), 9);
    done = 1'b0;
    for (int i = 0; i < LOSS_TIMEOUT + 16 && !done; i++) begin
      send(rand_data(), 9);
      if (!locked_o) done = 1'b1;
    end
    drop_cyc = cyc;
    chk("wrap_drop",      32'(locked_o),    0);
    chk("wrap_drop_off",  32'(offset_o),    9);
    chk("wrap_drop_loss", 32'(lock_loss_o), 32'(LOSS_ONE));
    done = 1'b0;
    for (int i = 0; i < SEARCH_WINDOW + 16 && !done; i++) begin
      send(rand_data(), 9);
      if (offset_o != 4'd9) done = 1'b1;
    end
    chk("wrap_offset0", 32'(offset_o),       0);
    chk("wrap_time",    32'(cyc - drop_cyc), 32'(SEARCH_WINDOW));
    chk("wrap_search",  32'(valid_o),        0);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
